nibble_trace_monitor: RTL and testbench

- Hardware counterpart to the stimulus/`$monitor` benches: a synthesizable monitor for a 4-bit stimulus bus and a 4-bit response bus.
- Each time either bus changes, it captures a timestamped record into an on-chip FIFO.
- The FIFO is drained through a valid/ready read port, so an on-board consumer (UART bridge, logic analyzer tap) can log DUT activity without simulation.

---
 rtl/trace_pkg.sv | 20 ++
 rtl/nibble_trace_monitor_if.sv | 17 +
 rtl/trace_fifo.sv | 57 +++++
 rtl/nibble_trace_monitor.sv | 83 ++++++++
 tb/tb_nibble_trace_monitor.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/trace_pkg.sv
// Shared widths and the record layout for the nibble trace monitor.
package trace_pkg;

   // Width of each monitored bus.
   localparam int NIB_W = 4;

   // Default timestamp width; the record struct below is built on it.
   localparam int TS_W_DEF = 12;

   // Full record width at the default timestamp width.
   localparam int REC_W = TS_W_DEF + 2 * NIB_W;

   // One captured record: timestamp in the MSBs, response bus in the LSBs.
   typedef struct packed {
      logic [TS_W_DEF-1:0] ts;
      logic [NIB_W-1:0]    arr;
      logic [NIB_W-1:0]    out;
   } trace_rec_t;

endpackage

// File: rtl/nibble_trace_monitor_if.sv
// Read port of the trace monitor.
// valid/ready: a record transfers on a rising clk edge where rd_valid and
// rd_ready are both high; rd_data holds the head record whenever rd_valid is
// high, and rd_valid never drops until that record transfers (except on
// clear/reset). rd_ready is ignored while rd_valid is low.
interface nibble_trace_monitor_if #(
   parameter int TS_W = 12
);
   logic              rd_valid;
   logic              rd_ready;
   logic [TS_W+7:0]   rd_data;

   // Monitor side drives the record and its valid.
   modport master (output rd_valid, output rd_data, input rd_ready);
   // Consumer side drives ready.
   modport slave  (input rd_valid, input rd_data, output rd_ready);
endinterface

// File: rtl/trace_fifo.sv
// Generic show-ahead synchronous FIFO; head entry is always on rd_data.
module trace_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 20
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     pop,
   input  logic                     flush,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      cnt;

   assign full    = (cnt == AW'(0) + (AW+1)'(DEPTH));
   assign empty   = (cnt == '0);
   assign count   = cnt;
   assign rd_data = mem[rd_ptr];

   // Storage is reset so the head reads zero out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (!flush && push) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   // Pointer and occupancy bookkeeping; flush wins over push and pop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         if (push && !pop)      cnt <= cnt + (AW+1)'(1);
         else if (pop && !push) cnt <= cnt - (AW+1)'(1);
      end
   end

endmodule

// File: rtl/nibble_trace_monitor.sv
// Captures a timestamped record whenever the stimulus or response nibble
// changes, and queues it for an on-board consumer.
import trace_pkg::*;

module nibble_trace_monitor #(
   parameter int DEPTH = 8,
   parameter int TS_W  = 12
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     en,
   input  logic                     clear,
   input  logic [NIB_W-1:0]         arr,
   input  logic [NIB_W-1:0]         out,
   nibble_trace_monitor_if.master   rd,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow
);

   localparam int RW = TS_W + 2 * NIB_W;

   logic [TS_W-1:0]    ts;
   logic [2*NIB_W-1:0] prev;
   logic [2*NIB_W-1:0] cur;
   logic               primed;
   logic               rec_req;
   logic               do_pop;
   logic               do_push;
   logic               drop;
   logic               fifo_full;
   logic               fifo_empty;
   logic [RW-1:0]      fifo_rd_data;

   assign cur     = {arr, out};
   // First enabled sample after reset/clear always records.
   assign rec_req = en && (!primed || (cur != prev));
   assign do_pop  = !fifo_empty && rd.rd_ready && !clear;
   // A full FIFO still accepts a record when the head leaves in the same cycle.
   assign do_push = rec_req && !clear && (!fifo_full || do_pop);
   assign drop    = rec_req && !clear && fifo_full && !do_pop;

   assign rd.rd_valid = !fifo_empty;
   assign rd.rd_data  = fifo_rd_data;

   // Timestamp, change-detector history and sticky overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ts       <= '0;
         prev     <= '0;
         primed   <= 1'b0;
         overflow <= 1'b0;
      end else if (clear) begin
         ts       <= '0;
         primed   <= 1'b0;
         overflow <= 1'b0;
      end else if (en) begin
         ts <= ts + TS_W'(1);
         // Dropped records still update prev so a held value is not re-logged.
         if (rec_req) begin
            prev   <= cur;
            primed <= 1'b1;
         end
         if (drop) overflow <= 1'b1;
      end
   end

   trace_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (RW)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push    (do_push),
      .wr_data ({ts, cur}),
      .pop     (do_pop),
      .flush   (clear),
      .rd_data (fifo_rd_data),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (count)
   );

endmodule

// File: tb/tb_nibble_trace_monitor.sv
// Directed bench for nibble_trace_monitor: a default instance (TS_W=12) and
// a narrow-timestamp instance (TS_W=4) for the wrap case.
import trace_pkg::*;

module tb_nibble_trace_monitor;

   logic       clk;
   logic       rst_n;
   logic       en,   clear;
   logic [3:0] arr,  out;
   logic [3:0] count;
   logic       overflow;
   logic       en_b, clear_b;
   logic [3:0] arr_b, out_b;
   logic [3:0] count_b;
   logic       overflow_b;

   int n_tests = 0;
   int n_fail  = 0;
   logic [19:0] exp_q[$];

   nibble_trace_monitor_if #(.TS_W(12)) rd_a ();
   nibble_trace_monitor_if #(.TS_W(4))  rd_b ();

   nibble_trace_monitor #(.DEPTH(8), .TS_W(12)) dut_a (
      .clk(clk), .rst_n(rst_n), .en(en), .clear(clear),
      .arr(arr), .out(out), .rd(rd_a),
      .count(count), .overflow(overflow)
   );

   nibble_trace_monitor #(.DEPTH(8), .TS_W(4)) dut_b (
      .clk(clk), .rst_n(rst_n), .en(en_b), .clear(clear_b),
      .arr(arr_b), .out(out_b), .rd(rd_b),
      .count(count_b), .overflow(overflow_b)
   );

   // clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // One comparison: counts it and reports any mismatch.
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Advance one edge and settle 1ns past it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_clear();
      en    = 1'b0;
      clear = 1'b1;
      tick();
      clear = 1'b0;
   endtask

   // Pop n records from instance A, comparing each against the scoreboard.
   task automatic drain_a(input int n, input string tag);
      logic [19:0] e;
      for (int i = 0; i < n; i++) begin
         e = exp_q.pop_front();
         check({tag, "_valid"}, 32'(rd_a.rd_valid), 32'd1);
         check({tag, "_data"},  32'(rd_a.rd_data),  32'(e));
         rd_a.rd_ready = 1'b1;
         tick();
         rd_a.rd_ready = 1'b0;
      end
   endtask

   function automatic logic [19:0] rec(input int t, input int a);
      trace_rec_t r;
      r.ts  = 12'(t);
      r.arr = 4'(a);
      r.out = 4'h0;
      return r;
   endfunction

   initial begin
      rst_n = 1'b0; en = 1'b0; clear = 1'b0; arr = '0; out = '0;
      en_b = 1'b0; clear_b = 1'b0; arr_b = '0; out_b = '0;
      rd_a.rd_ready = 1'b0;
      rd_b.rd_ready = 1'b0;
      #12;

      // reset state
      check("rst_valid",    32'(rd_a.rd_valid), 32'd0);
      check("rst_count",    32'(count),         32'd0);
      check("rst_overflow", 32'(overflow),      32'd0);
      check("rst_data",     32'(rd_a.rd_data),  32'd0);
      tick();
      rst_n = 1'b1;

      // held bus produces exactly one record
      en = 1'b1; arr = 4'b0111; out = 4'b1000;
      tick();
      check("hold_valid_1st", 32'(rd_a.rd_valid), 32'd1);
      check("hold_data",      32'(rd_a.rd_data),  32'h00078);
      for (int i = 0; i < 9; i++) tick();
      check("hold_count", 32'(count), 32'd1);
      out = 4'h0;
      en  = 1'b0;
      rd_a.rd_ready = 1'b1;
      tick();
      rd_a.rd_ready = 1'b0;
      check("hold_drained", 32'(count), 32'd0);
      do_clear();

      // changes at ts 3, 5, 9 with no reads
      en = 1'b1;
      for (int k = 0; k < 10; k++) begin
         arr = (k < 3) ? 4'd0 : (k < 5) ? 4'd1 : (k < 9) ? 4'd2 : 4'd3;
         tick();
      end
      en = 1'b0;
      check("chg_count", 32'(count), 32'd4);
      exp_q.push_back(rec(0, 0));
      exp_q.push_back(rec(3, 1));
      exp_q.push_back(rec(5, 2));
      exp_q.push_back(rec(9, 3));
      drain_a(4, "chg");
      do_clear();

      // toggling every cycle into a full FIFO
      en = 1'b1;
      for (int k = 0; k < 8; k++) begin
         arr = 4'(k);
         tick();
      end
      check("ovf_count_full", 32'(count),    32'd8);
      check("ovf_not_yet",    32'(overflow), 32'd0);
      for (int k = 8; k < 12; k++) begin
         arr = 4'(k);
         tick();
         if (k == 8) check("ovf_first_drop", 32'(overflow), 32'd1);
      end
      en = 1'b0;
      check("ovf_count_sat", 32'(count),    32'd8);
      check("ovf_sticky",    32'(overflow), 32'd1);
      for (int k = 0; k < 8; k++) exp_q.push_back(rec(k, k));
      drain_a(8, "ovf");
      check("ovf_sticky_empty", 32'(overflow), 32'd1);
      do_clear();
      check("clr_overflow", 32'(overflow), 32'd0);

      // full FIFO with push and pop in the same cycle
      en = 1'b1;
      for (int k = 0; k < 8; k++) begin
         arr = 4'(k);
         tick();
      end
      arr = 4'd8;
      rd_a.rd_ready = 1'b1;
      tick();
      rd_a.rd_ready = 1'b0;
      en = 1'b0;
      check("pp_count",    32'(count),    32'd8);
      check("pp_overflow", 32'(overflow), 32'd0);
      for (int k = 1; k < 9; k++) exp_q.push_back(rec(k, k));
      drain_a(8, "pp");
      do_clear();

      // clear with count=5 and a change in the same cycle
      en = 1'b1;
      for (int k = 0; k < 5; k++) begin
         arr = 4'(k);
         tick();
      end
      check("clr_pre_count", 32'(count), 32'd5);
      arr   = 4'd9;
      clear = 1'b1;
      tick();
      clear = 1'b0;
      check("clr_count",    32'(count),        32'd0);
      check("clr_ovf",      32'(overflow),     32'd0);
      check("clr_valid",    32'(rd_a.rd_valid), 32'd0);
      tick();
      check("clr_rec_count", 32'(count),        32'd1);
      check("clr_rec_data",  32'(rd_a.rd_data), 32'(rec(0, 9)));
      arr = 4'd10;
      tick();
      en = 1'b0;
      check("clr_rec_count2", 32'(count), 32'd2);

      // asynchronous reset in the middle of a drain
      rd_a.rd_ready = 1'b1;
      tick();
      check("mid_drain_count", 32'(count), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_valid", 32'(rd_a.rd_valid), 32'd0);
      check("async_count", 32'(count),         32'd0);
      check("async_data",  32'(rd_a.rd_data),  32'd0);
      rd_a.rd_ready = 1'b0;
      exp_q.delete();
      tick();
      rst_n = 1'b1;

      // narrow timestamp wraps: changes at cycles 15 and 17
      en_b = 1'b1;
      for (int c = 0; c < 20; c++) begin
         arr_b = (c < 15) ? 4'd0 : (c < 17) ? 4'd1 : 4'd2;
         tick();
      end
      en_b = 1'b0;
      check("wrap_count", 32'(count_b), 32'd3);
      check("wrap_rec0", 32'(rd_b.rd_data), 32'h000);
      rd_b.rd_ready = 1'b1;
      tick();
      check("wrap_rec1", 32'(rd_b.rd_data), 32'hF10);
      tick();
      check("wrap_rec2", 32'(rd_b.rd_data), 32'h120);
      tick();
      rd_b.rd_ready = 1'b0;
      check("wrap_empty", 32'(rd_b.rd_valid), 32'd0);
      check("wrap_ovf",   32'(overflow_b),    32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
